// File: rtl/counter_event_monitor.sv
// Event monitor for the up/down counter host: counts overflow/underflow edges, queues tagged snapshots, raises an acked alarm.
// Optional COUNTER_EVT_TIMESTAMP_EN prepends a 16-bit free-running cycle stamp to every FIFO entry.
module counter_event_monitor #(
  parameter int COUNTER_WIDTH = 16,
  parameter int EVT_CNT_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ALARM_THRESH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [COUNTER_WIDTH-1:0]         counter_value,
  input  logic                             counter_overflow,
  input  logic                             counter_underflow,
  input  logic                             clear,
  input  logic                             evt_ready,
  input  logic                             alarm_ack,
  output logic                             evt_valid,
`ifdef COUNTER_EVT_TIMESTAMP_EN
  output logic [COUNTER_WIDTH+17:0]        evt_data,
`else
  output logic [COUNTER_WIDTH+1:0]         evt_data,
`endif
  output logic [EVT_CNT_WIDTH-1:0]         ovf_count,
  output logic [EVT_CNT_WIDTH-1:0]         udf_count,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             evt_dropped,
  output logic                             alarm
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef COUNTER_EVT_TIMESTAMP_EN
  localparam int ENTRY_W = COUNTER_WIDTH + 18;
`else
  localparam int ENTRY_W = COUNTER_WIDTH + 2;
`endif

  localparam logic [EVT_CNT_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [PTR_W-1:0]         PTR_ONE  = 1;
  localparam logic [LVL_W-1:0]         LVL_ONE  = 1;
  localparam logic [LVL_W-1:0]         LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [EVT_CNT_WIDTH:0]   THRESH_V = (EVT_CNT_WIDTH+1)'(ALARM_THRESH);

  typedef enum logic [1:0] {NORMAL, ALARMED, ACKED} alarm_state_t;

  alarm_state_t               state;
  logic                       ovf_q;
  logic                       udf_q;
  logic                       ovf_ev;
  logic                       udf_ev;
  logic                       any_ev;
  logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]         new_entry;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic                       fifo_full;
  logic                       push;
  logic                       pop;
  logic [EVT_CNT_WIDTH:0]     total;

  assign ovf_ev    = counter_overflow & ~ovf_q;
  assign udf_ev    = counter_underflow & ~udf_q;
  assign any_ev    = ovf_ev | udf_ev;
  assign fifo_full = (fifo_level == LVL_FULL);
  assign evt_valid = (fifo_level != '0);
  assign evt_data  = mem[rd_ptr];

  // clear wins over both sides of the FIFO; a full FIFO still accepts a push when the head leaves this cycle
  assign pop  = evt_valid & evt_ready & ~clear;
  assign push = any_ev & ~clear & (~fifo_full | pop);
  assign total = {1'b0, ovf_count} + {1'b0, udf_count};

`ifdef COUNTER_EVT_TIMESTAMP_EN
  logic [15:0] timestamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timestamp <= '0;
    else     timestamp <= timestamp + 16'd1;
  end

  assign new_entry = {timestamp, udf_ev, ovf_ev, counter_value};
`else
  assign new_entry = {udf_ev, ovf_ev, counter_value};
`endif

  // Edge-detect registers track the raw flags even through clear, so a held flag is not seen as new afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= counter_overflow;
      udf_q <= counter_underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      evt_dropped <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      evt_dropped <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (any_ev && !push) evt_dropped <= 1'b1;
    end
  end

  // Saturating event counters; a dropped event is still counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
      udf_count <= '0;
    end else if (clear) begin
      ovf_count <= '0;
      udf_count <= '0;
    end else begin
      if (ovf_ev && (ovf_count != '1)) ovf_count <= ovf_count + CNT_ONE;
      if (udf_ev && (udf_count != '1)) udf_count <= udf_count + CNT_ONE;
    end
  end

  // The FSM looks at the already-updated counters, so alarm lands one cycle after the qualifying count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
      alarm <= 1'b0;
    end else if (clear) begin
      state <= NORMAL;
      alarm <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          if (total >= THRESH_V) begin
            state <= ALARMED;
            alarm <= 1'b1;
          end
        end
        ALARMED: begin
          if (alarm_ack) begin
            state <= ACKED;
            alarm <= 1'b0;
          end
        end
        ACKED: begin
          alarm <= 1'b0;
        end
        default: begin
          state <= NORMAL;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_event_monitor.sv
// Scoreboard bench for counter_event_monitor: stimulus queues expected FIFO entries, a negedge monitor pops and compares.
module tb_counter_event_monitor;

  logic        clk;
  logic        rst;
  logic [15:0] counter_value;
  logic        counter_overflow;
  logic        counter_underflow;
  logic        clear;
  logic        evt_ready;
  logic        alarm_ack;
  logic        evt_valid;
`ifdef COUNTER_EVT_TIMESTAMP_EN
  logic [33:0] evt_data;
`else
  logic [17:0] evt_data;
`endif
  logic [7:0]  ovf_count;
  logic [7:0]  udf_count;
  logic [2:0]  fifo_level;
  logic        evt_dropped;
  logic        alarm;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] sb_queue[$];

  counter_event_monitor #(
    .COUNTER_WIDTH(16),
    .EVT_CNT_WIDTH(8),
    .FIFO_DEPTH(4),
    .ALARM_THRESH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .counter_value(counter_value),
    .counter_overflow(counter_overflow),
    .counter_underflow(counter_underflow),
    .clear(clear),
    .evt_ready(evt_ready),
    .alarm_ack(alarm_ack),
    .evt_valid(evt_valid),
    .evt_data(evt_data),
    .ovf_count(ovf_count),
    .udf_count(udf_count),
    .fifo_level(fifo_level),
    .evt_dropped(evt_dropped),
    .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle flag pulse followed by an idle cycle so the next pulse is a fresh edge
  task automatic apply_stimulus(input logic ovf, input logic udf, input logic [15:0] value, input logic exp_push);
    counter_overflow  = ovf;
    counter_underflow = udf;
    counter_value     = value;
    if (exp_push) sb_queue.push_back({udf, ovf, value});
    tick();
    counter_overflow  = 1'b0;
    counter_underflow = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    logic saved_ready;
    saved_ready = evt_ready;
    evt_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    evt_ready = saved_ready;
    sb_queue.delete();
  endtask

  // Monitor: whenever a handshake will complete at the next edge, the head must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready && !clear) begin
      if (sb_queue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_entry: got %h expected none", evt_data[17:0]);
      end else begin
        check_output("evt_data", {14'd0, evt_data[17:0]}, {14'd0, sb_queue.pop_front()});
      end
    end
  end

  initial begin
    rst               = 1'b1;
    counter_value     = '0;
    counter_overflow  = 1'b0;
    counter_underflow = 1'b0;
    clear             = 1'b0;
    evt_ready         = 1'b0;
    alarm_ack         = 1'b0;
    #12;
    check_output("rst_valid", {31'd0, evt_valid}, 32'd0);
    check_output("rst_ovf", {24'd0, ovf_count}, 32'd0);
    check_output("rst_udf", {24'd0, udf_count}, 32'd0);
    check_output("rst_level", {29'd0, fifo_level}, 32'd0);
    check_output("rst_alarm", {31'd0, alarm}, 32'd0);
    rst = 1'b0;
    tick();

    // Single overflow, consumed immediately
    evt_ready        = 1'b1;
    counter_overflow = 1'b1;
    counter_value    = 16'hFFFF;
    sb_queue.push_back({2'b01, 16'hFFFF});
    tick();
    counter_overflow = 1'b0;
    check_output("single_valid", {31'd0, evt_valid}, 32'd1);
    check_output("single_ovf", {24'd0, ovf_count}, 32'd1);
    tick();
    check_output("single_popped", {31'd0, evt_valid}, 32'd0);

    // Flag held for three cycles yields one event
    counter_overflow = 1'b1;
    counter_value    = 16'h0010;
    sb_queue.push_back({2'b01, 16'h0010});
    repeat (3) tick();
    counter_overflow = 1'b0;
    tick();
    check_output("held_ovf", {24'd0, ovf_count}, 32'd2);
    apply_stimulus(1'b1, 1'b1, 16'h0000, 1'b1);
    check_output("both_ovf", {24'd0, ovf_count}, 32'd3);
    check_output("both_udf", {24'd0, udf_count}, 32'd1);

    // Backpressure: fifth event is dropped
    do_clear();
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b0, 1'b1, 16'(i), (i <= 4));
    check_output("full_level", {29'd0, fifo_level}, 32'd4);
    check_output("full_dropped", {31'd0, evt_dropped}, 32'd1);
    check_output("full_udf", {24'd0, udf_count}, 32'd5);
    evt_ready = 1'b1;
    repeat (6) tick();
    check_output("drain_level", {29'd0, fifo_level}, 32'd0);
    check_output("drain_sb_empty", sb_queue.size(), 32'd0);

    // Full FIFO with a same-cycle pop accepts the new event
    do_clear();
    check_output("clear_dropped", {31'd0, evt_dropped}, 32'd0);
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 16'h0021 + 16'(i), 1'b1);
    evt_ready         = 1'b1;
    counter_underflow = 1'b1;
    counter_value     = 16'h0025;
    sb_queue.push_back({2'b10, 16'h0025});
    tick();
    evt_ready         = 1'b0;
    counter_underflow = 1'b0;
    check_output("pushpop_level", {29'd0, fifo_level}, 32'd4);
    check_output("pushpop_dropped", {31'd0, evt_dropped}, 32'd0);
    evt_ready = 1'b1;
    repeat (6) tick();
    check_output("pushpop_sb_empty", sb_queue.size(), 32'd0);

    // Alarm fires one cycle after the eighth count lands
    do_clear();
    for (int i = 0; i < 7; i++) apply_stimulus(i % 2 == 0, i % 2 == 1, 16'h0100 + 16'(i), 1'b1);
    counter_underflow = 1'b1;
    counter_value     = 16'h0107;
    sb_queue.push_back({2'b10, 16'h0107});
    tick();
    counter_underflow = 1'b0;
    check_output("alarm_not_early", {31'd0, alarm}, 32'd0);
    check_output("alarm_udf", {24'd0, udf_count}, 32'd4);
    tick();
    check_output("alarm_fired", {31'd0, alarm}, 32'd1);
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    check_output("alarm_acked", {31'd0, alarm}, 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b1);
    check_output("alarm_no_refire", {31'd0, alarm}, 32'd0);
    do_clear();
    check_output("clear_ovf", {24'd0, ovf_count}, 32'd0);
    check_output("clear_udf", {24'd0, udf_count}, 32'd0);
    for (int i = 0; i < 8; i++) apply_stimulus(i % 2 == 0, i % 2 == 1, 16'h0300 + 16'(i), 1'b1);
    check_output("alarm_refire", {31'd0, alarm}, 32'd1);

    // Saturation
    do_clear();
    for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 1'b0, 16'(i), 1'b1);
    check_output("sat_ovf", {24'd0, ovf_count}, 32'd255);

    // clear beats a coincident event; the held flag stays unseen afterwards
    do_clear();
    counter_overflow = 1'b1;
    counter_value    = 16'h0ABC;
    clear            = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check_output("clear_ev_ovf", {24'd0, ovf_count}, 32'd0);
    check_output("clear_ev_valid", {31'd0, evt_valid}, 32'd0);
    counter_overflow = 1'b0;
    tick();

    // Asynchronous reset with entries pending
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 16'h0400 + 16'(i), 1'b1);
    check_output("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_valid", {31'd0, evt_valid}, 32'd0);
    check_output("async_rst_level", {29'd0, fifo_level}, 32'd0);
    sb_queue.delete();
    tick();
    rst = 1'b0;
    tick();
    check_output("post_rst_level", {29'd0, fifo_level}, 32'd0);
    check_output("final_sb_empty", sb_queue.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_event_monitor.md
Name: counter_event_monitor

Overview:
- Downstream consumer of the up/down counter host.
- Watches the host's counter_value, counter_overflow and counter_underflow outputs, and counts overflow and underflow events.
- Captures a tagged snapshot of counter_value per event into a small FIFO, drained by a valid/ready handshake.
- Raises an acknowledged alarm when the total event count reaches a threshold.

Parameters:
- COUNTER_WIDTH, 16, width of counter_value (matches host).
- EVT_CNT_WIDTH, 8, width of the ovf_count and udf_count saturating counters.
- FIFO_DEPTH, 4, snapshot FIFO entries; must be a power of 2 and at least 2.
- ALARM_THRESH, 8, total-event threshold that fires the alarm.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- counter_value  in  COUNTER_WIDTH  host counter output.
- counter_overflow  in  1  host overflow flag.
- counter_underflow  in  1  host underflow flag.
- clear  in  1  synchronous clear of all monitor state.
- evt_ready  in  1  consumer ready.
- alarm_ack  in  1  alarm acknowledge.
- evt_valid  out  1  FIFO head valid.
- evt_data  out  COUNTER_WIDTH+2  FIFO head, {type[1:0], value}.
- ovf_count  out  EVT_CNT_WIDTH  overflow events, saturating.
- udf_count  out  EVT_CNT_WIDTH  underflow events, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- evt_dropped  out  1  sticky; an event was lost because the FIFO was full.
- alarm  out  1  alarm request.

Behaviour:
- Reset: all outputs 0, FIFO empty, alarm FSM in NORMAL, edge-detect registers 0.
- Event detection:
  - ovf_ev = counter_overflow & ~ovf_q; udf_ev = counter_underflow & ~udf_q.
  - ovf_q and udf_q are the inputs registered every cycle.
  - A flag held high for several cycles yields exactly one event.
- Event type: 2'b01 overflow, 2'b10 underflow, 2'b11 both in the same cycle (one entry, both counters increment).
- Push: on any event, push {type, counter_value} using counter_value sampled in that same cycle.
  - Counter update is visible one cycle after the event.
  - FIFO push is visible one cycle after the event; evt_valid rises that cycle if the FIFO was empty.
- Pop: occurs when evt_valid & evt_ready.
  - evt_data presents the head entry combinationally from FIFO storage and is stable while evt_valid & ~evt_ready.
- FIFO full:
  - Push and pop in the same cycle: both occur, level unchanged.
  - Push without pop: entry discarded, evt_dropped <= 1, counters still increment.
- FIFO empty: a pop attempt is impossible because evt_valid = 0.
- Pointers: wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- Counters: saturate at all-ones and never wrap.
- Alarm total: ovf_count + udf_count, computed at EVT_CNT_WIDTH+1 bits, no overflow.
- Alarm FSM:
  - NORMAL: alarm=0. Go to ALARM when the post-update total >= ALARM_THRESH; alarm=1 on the cycle after the qualifying counter update.
  - ALARM: alarm=1. Go to ACKED on alarm_ack.
  - ACKED: alarm=0. No re-fire while in ACKED; leave only via clear or rst.
  - alarm_ack in NORMAL or ACKED is ignored.
- clear:
  - Next edge: counters 0, FIFO empty, evt_dropped 0, FSM to NORMAL.
  - clear beats any event or pop in the same cycle; that event is not recorded.
  - Edge-detect registers still update during clear, so a flag that stays high is not re-detected after clear.
- rst asserted mid-transfer: FIFO contents and any unpopped head are lost; evt_valid drops immediately (async).

Optional Feature:
- Macro: COUNTER_EVT_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0 by rst, unaffected by clear, wraps at 16'hFFFF -> 0.
  - evt_data widens to COUNTER_WIDTH+18 as {timestamp, type, value}; timestamp is sampled in the event cycle.
- Undefined: no timestamp logic; evt_data is COUNTER_WIDTH+2 bits as above.

Test Plan:
- Single overflow: overflow pulse 1 cycle with counter_value=16'hFFFF, evt_ready=1 -> next cycle evt_valid=1, evt_data={2'b01,16'hFFFF}, ovf_count=1; popped; evt_valid=0 the cycle after.
- Held flag plus simultaneous events: counter_overflow held 3 cycles -> ovf_count=1, one entry. Both flags rising together with value 16'h0000 -> one entry {2'b11,16'h0000}, ovf_count and udf_count each +1.
- Backpressure and full: evt_ready=0, 5 underflow events with values 1..5 at depth 4 -> fifo_level=4, evt_dropped=1, udf_count=5. Drain -> values 1,2,3,4 in order. Event while full with evt_ready=1 -> no drop, level stays 4.
- Alarm: 8 alternating events -> alarm=1 one cycle after 8th count update; alarm_ack -> alarm=0. 4 more events -> alarm stays 0. clear -> all counts 0; 8 more events -> alarm re-fires.
- Saturation: 300 overflow events, EVT_CNT_WIDTH=8 -> ovf_count=255 and holds.
- Mid-operation: clear coincident with an event -> event not recorded, counts 0. rst asserted with FIFO level 3 -> evt_valid=0 and fifo_level=0 immediately.
